// File: rtl/hex_keypad_pkg.sv
// Shared definitions for the hex keypad emulator and its scanner/encoder:
// FSM state encoding and the key-code to row/column mapping.
package hex_keypad_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_BNC_IN  = 5'b00010,
    ST_HOLD    = 5'b00100,
    ST_BNC_OUT = 5'b01000,
    ST_GAP     = 5'b10000
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Key code layout: [3:2] row index, [1:0] column index.
  function automatic logic [1:0] key_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return code[1:0];
  endfunction

  // Row lines produced by a closed key under a given column drive.
  function automatic logic [3:0] key_row_lines(input logic [3:0] code,
                                               input logic [3:0] col);
    return onehot4(key_row(code)) & {4{col[key_col(code)]}};
  endfunction

endpackage

// File: rtl/hex_keypad_emulator_sync_2ff.sv
// One-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hex_keypad_emulator.sv
// 4x4 hex keypad emulator: presses a commanded key with contact bounce, hold,
// bounced release and a release gap, answering the scanner's column drive.
module hex_keypad_emulator
  import hex_keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       S_Row,
  output logic       pressed,
  output logic       done
);

  localparam logic [CNT_W-1:0] BNC_LOAD  =
    (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       code;
  logic             contact;
  logic             done_q;
  logic             row_any;

  // Contact is registered one phase ahead: each transition also sets the
  // first contact value of the phase being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      code    <= '0;
      contact <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (key_valid) begin
            code    <= key_code;
            contact <= 1'b1;
            if (BOUNCE_CYCLES > 0) begin
              state <= ST_BNC_IN;
              cnt   <= BNC_LOAD;
            end else begin
              state <= ST_HOLD;
              cnt   <= HOLD_LOAD;
            end
          end
        end
        ST_BNC_IN: begin
          if (cnt == '0) begin
            state   <= ST_HOLD;
            cnt     <= HOLD_LOAD;
            contact <= 1'b1;
          end else begin
            cnt     <= cnt - CNT_ONE;
            contact <= ~contact;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            contact <= 1'b0;
            if (BOUNCE_CYCLES > 0) begin
              state <= ST_BNC_OUT;
              cnt   <= BNC_LOAD;
            end else begin
              state <= ST_GAP;
              cnt   <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_BNC_OUT: begin
          if (cnt == '0) begin
            state   <= ST_GAP;
            cnt     <= GAP_LOAD;
            contact <= 1'b0;
          end else begin
            cnt     <= cnt - CNT_ONE;
            contact <= ~contact;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          contact <= 1'b0;
        end
      endcase
    end
  end

  // Row stays combinational from Col: the scanner drives Col from its state.
  always_comb begin
    Row = '0;
    if (contact) Row = key_row_lines(code, Col);
  end

  assign row_any   = |Row;
  assign key_ready = (state == ST_IDLE);
  assign pressed   = contact;
  assign done      = done_q;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (row_any),
    .q     (S_Row)
  );

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Directed bench for hex_keypad_emulator: one instance with default timing,
// one bounce-free instance with long hold for mapping and closed-loop scans.
module tb_hex_keypad_emulator;

  logic clock;
  logic reset;

  logic [3:0] dut_code, dut_col, dut_row;
  logic       dut_valid, dut_ready, dut_srow, dut_pressed, dut_done;
  logic [3:0] nb_code, nb_col, nb_row;
  logic       nb_valid, nb_ready, nb_srow, nb_pressed, nb_done;

  int n_tests = 0;
  int n_fail  = 0;

  hex_keypad_emulator u_dut (
    .clock     (clock),
    .reset     (reset),
    .key_code  (dut_code),
    .key_valid (dut_valid),
    .key_ready (dut_ready),
    .Col       (dut_col),
    .Row       (dut_row),
    .S_Row     (dut_srow),
    .pressed   (dut_pressed),
    .done      (dut_done)
  );

  hex_keypad_emulator #(
    .BOUNCE_CYCLES (0),
    .HOLD_CYCLES   (32),
    .GAP_CYCLES    (8),
    .CNT_W         (8)
  ) u_nb (
    .clock     (clock),
    .reset     (reset),
    .key_code  (nb_code),
    .key_valid (nb_valid),
    .key_ready (nb_ready),
    .Col       (nb_col),
    .Row       (nb_row),
    .S_Row     (nb_srow),
    .pressed   (nb_pressed),
    .done      (nb_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Default-parameter contact sequence, cycle 1 = first cycle after accept.
  function automatic logic exp_contact(input int k);
    if (k >= 1 && k <= 4)  return (k % 2) == 1;
    if (k >= 5 && k <= 20) return 1'b1;
    if (k >= 21 && k <= 24) return (k % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic [1:0] row_idx(input logic [3:0] r);
    case (r)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic dut_accept(input logic [3:0] k);
    @(negedge clock);
    dut_code  = k;
    dut_valid = 1'b1;
    @(posedge clock);
    #1 dut_valid = 1'b0;
  endtask

  task automatic nb_accept(input logic [3:0] k);
    @(negedge clock);
    nb_code  = k;
    nb_valid = 1'b1;
    @(posedge clock);
    #1 nb_valid = 1'b0;
  endtask

  task automatic wait_done(input bit use_nb, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if ((use_nb && nb_done) || (!use_nb && dut_done)) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [3:0] pats [5];
    logic [3:0] kc, pat, exp_row, found_code;
    logic [3:0] loop_keys [3];
    bit         found;

    pats      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
    loop_keys = '{4'h0, 4'h5, 4'hC};
    reset = 1'b1;
    dut_code = '0; dut_valid = 1'b0; dut_col = '0;
    nb_code  = '0; nb_valid  = 1'b0; nb_col  = '0;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_row",   32'(dut_row),     32'h0);
    check("rst_srow",  32'(dut_srow),    32'h0);
    check("rst_press", 32'(dut_pressed), 32'h0);
    check("rst_done",  32'(dut_done),    32'h0);
    check("rst_ready", 32'(dut_ready),   32'h1);
    reset = 1'b0;

    // Bounce and phase timing, key 6, Col all ones
    dut_col = 4'hF;
    dut_accept(4'h6);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      check("timing_pressed", 32'(dut_pressed), 32'(exp_contact(k)));
      check("timing_done",    32'(dut_done),    32'(k == 33));
      check("timing_ready",   32'(dut_ready),   32'(k == 33));
      if (k >= 3) check("timing_srow", 32'(dut_srow), 32'(exp_contact(k - 2)));
      if (k == 10) check("timing_row", 32'(dut_row), 32'h2);
    end

    // Busy handling: 0x3 held valid during 0x9 press, back-to-back at done
    @(negedge clock);
    dut_code  = 4'h9;
    dut_valid = 1'b1;
    @(posedge clock);
    #1 dut_code = 4'h3;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      if (k < 33) check("busy_ready", 32'(dut_ready), 32'h0);
      if (k == 10) check("busy_row", 32'(dut_row), 32'h4);
      if (k == 33) begin
        check("busy_done",  32'(dut_done),  32'h1);
        check("busy_ready_done", 32'(dut_ready), 32'h1);
      end
    end
    @(posedge clock);
    #1 dut_valid = 1'b0;
    @(negedge clock);
    check("b2b_pressed1", 32'(dut_pressed), 32'h1);
    check("b2b_ready",    32'(dut_ready),   32'h0);
    check("b2b_row",      32'(dut_row),     32'h1);
    @(negedge clock);
    check("b2b_pressed2", 32'(dut_pressed), 32'h0);
    wait_done(1'b0, 40, "b2b_done_wait");

    // Reset mid-HOLD with key F, Col 1000
    dut_col = 4'b1000;
    dut_accept(4'hF);
    repeat (10) @(negedge clock);
    check("midrst_row_before", 32'(dut_row), 32'h8);
    #2 reset = 1'b1;
    #1;
    check("midrst_row",   32'(dut_row),     32'h0);
    check("midrst_ready", 32'(dut_ready),   32'h1);
    check("midrst_press", 32'(dut_pressed), 32'h0);
    @(negedge clock);
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("midrst_no_done", 32'(dut_done), 32'h0);
      if (i >= 1) check("midrst_srow", 32'(dut_srow), 32'h0);
    end

    // Mapping sweep on the bounce-free instance
    for (int k = 0; k < 16; k++) begin
      kc = 4'(k);
      nb_accept(kc);
      for (int p = 0; p < 5; p++) begin
        @(negedge clock);
        pat    = pats[p];
        nb_col = pat;
        #1;
        exp_row = pat[kc[1:0]] ? (4'b0001 << kc[3:2]) : 4'b0000;
        check("map_row", 32'(nb_row), 32'(exp_row));
      end
      if (k == 10) begin
        @(negedge clock);
        nb_col = 4'b0100;
        #1 check("map_a_0100", 32'(nb_row), 32'h4);
        nb_col = 4'b0010;
        #1 check("map_a_0010", 32'(nb_row), 32'h0);
      end
      wait_done(1'b1, 60, "map_done_wait");
    end

    // Closed loop with a column-scanning encoder model
    for (int j = 0; j < 3; j++) begin
      nb_accept(loop_keys[j]);
      found      = 1'b0;
      found_code = '0;
      for (int c = 0; c < 4; c++) begin
        if (!found) begin
          @(negedge clock);
          nb_col = 4'b0001 << c;
          repeat (3) @(negedge clock);
          if (nb_srow) begin
            found      = 1'b1;
            found_code = {row_idx(nb_row), 2'(c)};
          end
        end
      end
      check("loop_valid", 32'(found), 32'h1);
      check("loop_code",  32'(found_code), 32'(loop_keys[j]));
      nb_col = '0;
      wait_done(1'b1, 60, "loop_done_wait");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hex_keypad_emulator.md
# hex_keypad_emulator

Behavioural-synthesizable emulator of a 4x4 hex keypad. It is the responder to the keypad scanner/encoder. It accepts key-press commands over a valid/ready handshake, then presses the addressed key with contact bounce, holds it, releases it with bounce, and enforces a release gap. While the key is closed, it drives `Row` in response to the scanner's `Col` drive and supplies the synchronized `S_Row` the scanner expects. It sits in the keypad test harness and in the FPGA self-test image, in place of the physical keypad.

## Interface
Parameters:
- `BOUNCE_CYCLES`, default 4: contact-toggle cycles on press and on release; 0 disables bounce.
- `HOLD_CYCLES`, default 16: cycles of stable closure; must be ≥ 1.
- `GAP_CYCLES`, default 8: cycles of stable open contact after release; must be ≥ 1.
- `CNT_W`, default 8: phase counter width; every cycle parameter must be < 2^CNT_W.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: one clock; reset is asynchronous and active-high.
- `key_code`  in  4: key to press; bits [3:2] are the row index, bits [1:0] the column index.
- `key_valid`  in  1: command valid.
- `key_ready`  out  1: high only in IDLE.
- `Col`  in  4: column drive from the scanner.
- `Row`  out  4: row lines as seen by the scanner.
- `S_Row`  out  1: two-flop synchronized OR of `Row`.
- `pressed`  out  1: contact currently closed.
- `done`  out  1: one-cycle pulse on return to IDLE.

## Operation
- Key mapping: `Row = contact ? (onehot4(code[3:2]) & {4{Col[code[1:0]]}}) : 4'b0`.
  - This is combinational from `Col` with no register in the path, because the scanner drives `Col` combinationally from its state.
  - Example: code 6 with `Col`=0100 gives `Row`=0010. `Col`=1111 always returns the key's row.
- A command is accepted when `key_valid && key_ready` at a rising edge. `key_code` is latched at acceptance. `key_valid` while busy is ignored; there is no queue.
- FSM, one-hot encoded, with states IDLE, BNC_IN, HOLD, BNC_OUT, GAP:
  - IDLE: contact 0. On accept, load the counter and go to BNC_IN, or to HOLD if `BOUNCE_CYCLES`=0.
  - BNC_IN: runs for `BOUNCE_CYCLES` cycles. Contact alternates 1,0,1,0…, starting at 1. Then go to HOLD.
  - HOLD: runs for `HOLD_CYCLES` cycles with contact 1. Then go to BNC_OUT, or to GAP if `BOUNCE_CYCLES`=0.
  - BNC_OUT: runs for `BOUNCE_CYCLES` cycles. Contact alternates 0,1,0,1…, starting at 0. Then go to GAP.
  - GAP: runs for `GAP_CYCLES` cycles with contact 0. Then go to IDLE and pulse `done` on the IDLE-entry cycle.
- A single down-counter of width `CNT_W` holds each phase's length. It is loaded at every state entry with length−1, and the transition fires when it reaches 0. The counter never wraps.
- `pressed` is the registered contact bit.
- `S_Row` = sync2(|Row). It lags `Row` by two cycles.

## Timing
- All outputs at reset: `Row`=0, `S_Row`=0, `pressed`=0, `done`=0, `key_ready`=1. Reset also returns the FSM to IDLE, clears the latched code and counter to 0, and clears the sync flops.
- Reset asserted mid-operation takes effect immediately (asynchronously). `Row` drops to 0 in the same cycle, and no `done` pulse is produced.
- Accept at edge T: `key_ready` falls after T, and contact first closes in cycle T+1.
- Defaults, with accept at edge 0:
  - Cycles 1–4: contact 1,0,1,0.
  - Cycles 5–20: contact 1.
  - Cycles 21–24: contact 0,1,0,1.
  - Cycles 25–32: contact 0.
  - Cycle 33: `done`=1 and `key_ready`=1.
- Total busy time is `2*BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES` cycles.
- A new accept is allowed in the same cycle that `done` pulses.
- A `Col` change is reflected on `Row` in the same cycle; there is zero latency.

## Structure
- Shared package `hex_keypad_pkg` holds:
  - the one-hot state constants for the five states;
  - `onehot4` and the key-to-row/column index helpers;
  - the code-to-(row, col) mapping, which the encoder's code table must agree with.
- One sub-module, `sync_2ff`: a 1-bit two-flop synchronizer with asynchronous active-high reset, used for `S_Row`.

## Test plan
- Reset check: assert `reset` mid-HOLD with key 0xF and `Col`=1000. Required: `Row`=0 immediately, `key_ready`=1, `S_Row`=0 after 2 cycles, no `done`.
- Mapping sweep: with `BOUNCE_CYCLES`=0, press each key 0–15 and drive `Col` ∈ {0001, 0010, 0100, 1000, 1111}. Required: `Row` matches the mapping, e.g. key 0xA with `Col`=0100 gives 0100 and with `Col`=0010 gives 0000.
- Bounce and phase timing: with defaults and key 0x6 and `Col`=1111, `pressed` must follow exactly the contact sequence listed under Timing, and `done` must appear at cycle 33.
- Busy handling: hold `key_valid`=1 with 0x3 during a 0x9 press. The 0x3 command must not be accepted until `done`. Back-to-back accept at the `done` cycle must start the next BNC_IN at the next cycle.
- Closed loop with the scanner/encoder: press keys 0x0, 0x5, 0xC in sequence with `HOLD_CYCLES`=32. Required: the encoder reports `Code`=0, 5, 12, with `Valid` high for each key.
